// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, shifter states and
// the SHIFT_STEP legality helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } shift_state_e;

    localparam logic [3:0] ALU_ILLEGAL_MIN = 4'b1010;

    localparam int SHIFT_STEP_MIN = 1;
    localparam int SHIFT_STEP_MAX = 8;

    // Legal steps are the powers of two between the min and max.
    function automatic bit shift_step_legal(input int step);
        return (step >= SHIFT_STEP_MIN) && (step <= SHIFT_STEP_MAX) &&
               ((step & (step - 1)) == 0);
    endfunction

    function automatic bit is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: moves the working value by up to SHIFT_STEP bits per cycle
// until the remaining shift amount is exhausted.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    flush,
    input  alu_op_e                 op,
    input  logic [XLEN-1:0]         value,
    input  logic [$clog2(XLEN)-1:0] amount,
    output logic                    busy,
    output logic                    done,
    output logic [XLEN-1:0]         result
);

    localparam int SHW = $clog2(XLEN);
    localparam int RW  = SHW + 4;
    // An illegal step setting falls back to single-bit stepping.
    localparam int STEP_EFF = shift_step_legal(SHIFT_STEP) ? SHIFT_STEP : 1;
    localparam logic [RW-1:0] STEP = RW'(STEP_EFF);

    shift_state_e    state;
    alu_op_e         op_q;
    logic [XLEN-1:0] working;
    logic [RW-1:0]   rem;
    logic [RW-1:0]   step;
    logic [XLEN-1:0] shifted;

    always_comb begin
        step    = (rem < STEP) ? rem : STEP;
        shifted = working;
        case (op_q)
            ALU_SLL: shifted = working << step;
            ALU_SRL: shifted = working >> step;
            ALU_SRA: shifted = $unsigned($signed(working) >>> step);
            default: shifted = working;
        endcase
    end

    assign busy   = (state == ST_SHIFT);
    assign done   = busy && (rem <= STEP);
    assign result = shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= ALU_SLL;
            working <= '0;
            rem     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        working <= value;
                        rem     <= {{(RW-SHW){1'b0}}, amount};
                        op_q    <= op;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    working <= shifted;
                    rem     <= rem - step;
                    if (rem <= STEP) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides; single-cycle ops
// complete at accept, non-zero shifts go through the iterative shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_ALUControl,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_illegal
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic            code_illegal;
    logic            accept;
    logic            shift_start;
    logic            shift_busy;
    logic            shift_done;
    logic [XLEN-1:0] shift_result;
    logic [XLEN-1:0] alu_result;

    assign shamt        = i_b[SHW-1:0];
    assign code_illegal = (i_ALUControl >= ALU_ILLEGAL_MIN);
    assign o_ready      = !shift_busy && !i_flush && (!o_valid || i_ready);
    assign accept       = i_valid && o_ready;
    assign shift_start  = accept && is_shift_op(i_ALUControl) && (shamt != '0);

    // Shifts only take this path with a zero amount, so they pass i_a through.
    always_comb begin
        alu_result = '0;
        case (i_ALUControl)
            ALU_ADD:  alu_result = i_a + i_b;
            ALU_SUB:  alu_result = i_a - i_b;
            ALU_AND:  alu_result = i_a & i_b;
            ALU_OR:   alu_result = i_a | i_b;
            ALU_XOR:  alu_result = i_a ^ i_b;
            ALU_SLT:  alu_result = XLEN'($signed(i_a) < $signed(i_b));
            ALU_SLTU: alu_result = XLEN'(i_a < i_b);
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_result = i_a;
            default:  alu_result = '0;
        endcase
    end

    alu_shift_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (shift_start),
        .flush  (i_flush),
        .op     (alu_op_e'(i_ALUControl)),
        .value  (i_a),
        .amount (shamt),
        .busy   (shift_busy),
        .done   (shift_done),
        .result (shift_result)
    );

    // Flush outranks both a new accept and a shift finishing on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_zero    <= 1'b0;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept && !shift_start) begin
            o_valid   <= 1'b1;
            o_result  <= alu_result;
            o_zero    <= (alu_result == '0);
            o_illegal <= code_illegal;
        end else if (shift_done) begin
            o_valid   <= 1'b1;
            o_result  <= shift_result;
            o_zero    <= (shift_result == '0);
            o_illegal <= 1'b0;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int XLEN      = 32;
    localparam int STEP      = 1;
    localparam int MAX_EDGES = 200;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            down_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (STEP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_valid      (in_valid),
        .o_ready      (out_ready),
        .i_ALUControl (ctrl),
        .i_a          (a),
        .i_b          (b),
        .o_valid      (out_valid),
        .i_ready      (down_ready),
        .o_result     (result),
        .o_zero       (zero),
        .o_illegal    (illegal)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] refResult(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        int n;
        n = int'(y % XLEN);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd6:    return x << n;
            4'd7:    return x >> n;
            4'd8:    return (x < y) ? 1 : 0;
            4'd9:    return x[XLEN-1] ? ~((~x) >> n) : (x >> n);
            default: return '0;
        endcase
    endfunction

    function automatic int refLatency(input logic [3:0] op, input logic [XLEN-1:0] y);
        int n;
        n = int'(y % XLEN);
        if ((op == 4'd6 || op == 4'd7 || op == 4'd9) && n != 0)
            return 1 + (n + STEP - 1) / STEP;
        return 1;
    endfunction

    // Called at a negedge with down_ready=1; returns at the negedge where the result is visible.
    task automatic applyStimulus(input logic [3:0] op, input logic [XLEN-1:0] opA, input logic [XLEN-1:0] opB);
        logic [XLEN-1:0] expRes;
        int expLat;
        int edges;
        int stalls;
        expRes = refResult(op, opA, opB);
        expLat = refLatency(op, opB);
        stalls = 0;
        ctrl     = op;
        a        = opA;
        b        = opB;
        in_valid = 1'b1;
        #1;
        checkOutput($sformatf("op%0d_ready_at_issue", op), out_ready, 1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        ctrl     = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        while (!out_valid && edges < MAX_EDGES) begin
            if (!out_ready) stalls++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput($sformatf("op%0d_latency", op), edges, expLat);
        checkOutput($sformatf("op%0d_ready_low_cycles", op), stalls, expLat - 1);
        checkOutput($sformatf("op%0d_result a=%0h b=%0h", op, opA, opB), result, expRes);
        checkOutput($sformatf("op%0d_zero", op), zero, (expRes == 0));
        checkOutput($sformatf("op%0d_illegal", op), illegal, (op >= 4'b1010));
    endtask

    initial begin
        int seen;
        logic [3:0] rop;

        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        down_ready = 1'b1;
        ctrl       = '0;
        a          = '0;
        b          = '0;
        #12;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_zero", zero, 0);
        checkOutput("reset_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", out_ready, 1);

        // Directed arithmetic, compare and shift cases
        applyStimulus(4'd0, 32'h7FFF_FFFF, 32'h1);
        applyStimulus(4'd1, 32'd5, 32'd5);
        applyStimulus(4'd5, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'h1);
        applyStimulus(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F);
        applyStimulus(4'd9, 32'h8000_0000, 32'h1F);
        applyStimulus(4'd7, 32'h8000_0000, 32'h1F);
        applyStimulus(4'd6, 32'h1, 32'h25);
        applyStimulus(4'd9, 32'h8000_0000, 32'h20);
        applyStimulus(4'b1100, 32'h1234, 32'h5678);
        applyStimulus(4'd0, 32'd3, 32'd4);

        // Backpressure: hold the ADD result, then pop and accept OR on one edge
        @(negedge clk);
        down_ready = 1'b0;
        ctrl       = 4'd0;
        a          = 32'd10;
        b          = 32'd20;
        in_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_result", result, 30);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_hold_result", result, 30);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_ready_low", out_ready, 0);
        end
        down_ready = 1'b1;
        ctrl       = 4'd3;
        a          = 32'h0000_00F0;
        b          = 32'h0000_000F;
        in_valid   = 1'b1;
        #1;
        checkOutput("bp_ready_comb", out_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_or_valid", out_valid, 1);
        checkOutput("bp_or_result", result, 32'hFF);

        // Flush an SLL of 20 once ten bits remain
        ctrl     = 4'd6;
        a        = 32'h1;
        b        = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_ready", out_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("flush_no_late_valid", seen, 0);

        // Reset pulsed while a shift is in flight
        applyStimulus(4'd0, 32'h1234, 32'h0);
        ctrl     = 4'd9;
        a        = 32'h8000_0000;
        b        = 32'd16;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", out_valid, 0);
        checkOutput("rst_mid_result", result, 0);
        checkOutput("rst_mid_zero", zero, 0);
        checkOutput("rst_mid_illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("rst_no_partial_result", seen, 0);
        checkOutput("rst_ready", out_ready, 1);
        applyStimulus(4'd7, 32'hF000_0000, 32'd4);

        // Random ops, including illegal codes and zero-amount shifts
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                rop = 4'($urandom_range(10, 15));
            else
                rop = 4'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       applyStimulus(rop, $urandom, 32'($urandom_range(0, 3)));
                1:       applyStimulus(rop, $urandom, $urandom & 32'hFFFF_FFE0);
                default: applyStimulus(rop, $urandom, $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder and produces the result and zero flag for the EX/MEM boundary. Add, subtract, logic and compare ops finish in one cycle. SLL/SRL/SRA use an iterative shifter that takes multiple cycles. A valid/ready handshake on both sides lets the hazard unit stall around variable-latency shifts.

Parameters:
XLEN, 32, datapath width; power of 2.
SHIFT_STEP, 1, bits shifted per iterative cycle; legal values 1, 2, 4, 8.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous abort of in-flight and pending ops
i_valid  input  1  upstream op valid
o_ready  output  1  unit can accept an op this cycle
i_ALUControl  input  4  op code: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SLTU 1000, SRA 1001
i_a  input  XLEN  operand A
i_b  input  XLEN  operand B; shift amount = i_b[$clog2(XLEN)-1:0]
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_result  output  XLEN  registered result
o_zero  output  1  registered (o_result == 0)
o_illegal  output  1  registered; code 1010-1111 was issued

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_valid 0, o_result 0, o_zero 0, o_illegal 0, shift counter 0.
- States:
  - IDLE: no shift in progress.
  - SHIFT: iterating. Holds working register, op and remaining count.
- o_ready = (state==IDLE) && !i_flush && (!o_valid || i_ready). This path is combinational from i_ready.
- Accept: an op is accepted on an edge where i_valid && o_ready. The accept edge counts as edge 1. Inputs are sampled only at accept; later changes to the inputs are ignored.
- Non-shift ops, and shifts with shift amount 0:
  - Result is written at the accept edge.
  - o_valid=1 the following cycle (latency 1).
- Shift with shift amount n>0:
  - Accept edge loads working=i_a and rem=n, and enters SHIFT.
  - Each SHIFT edge shifts by min(SHIFT_STEP, rem) and sets rem -= that amount.
  - The edge on which rem reaches 0 writes o_result and o_zero, sets o_valid=1 and returns to IDLE.
  - Total latency = 1 + ceil(n/SHIFT_STEP) edges.
  - o_valid is 0 throughout SHIFT. If the previous result is popped at the accept edge, the output slot empties.
- Output hold: while o_valid && !i_ready, o_result, o_zero and o_illegal stay stable.
- o_valid clears on an edge where i_ready=1, unless a new single-cycle op is accepted on that same edge (back-to-back throughput 1/cycle).
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN.
  - SLT compares signed; SLTU compares unsigned. Both give 1 or 0, zero-extended.
  - SRA fills with i_a[XLEN-1]; SLL/SRL fill with 0.
  - Upper bits of i_b are ignored for shifts.
- Illegal code: o_result=0, o_zero=1, o_illegal=1, latency 1. This is not an error stop; the unit continues normally.
- Flush: i_flush=1 at an edge forces state IDLE, o_valid 0 and rem 0. It has priority over accept and over SHIFT completion.
- Reset asserted mid-SHIFT: immediate return to reset values. No partial result becomes visible.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum holding the 10 op codes, shared with the ALU decoder.
  - ALU_ILLEGAL_MIN constant = 4'b1010.
  - localparams for the SHIFT_STEP legality check.
- Sub-module alu_shift_unit:
  - Owns the working register, rem counter and direction/fill logic.
  - Interface: start, op, value, amount, flush; returns done and result.
- alu_exec_unit keeps the combinational ALU, the handshake and the output register.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> o_result 0x80000000, o_zero 0, o_valid the cycle after accept. SUB a=5, b=5 -> o_result 0, o_zero 1.
- SLT a=0xFFFFFFFF, b=1 -> 1. SLTU with same operands -> 0. XOR a=0xFFFF0000, b=0x0F0F0F0F -> 0xF0F00F0F.
- SHIFT_STEP=1:
  - SRA a=0x80000000, b=0x1F -> o_valid after 32 edges, result 0xFFFFFFFF. o_ready is 0 for those 31 SHIFT cycles.
  - SRL with same operands -> 0x00000001.
  - SLL a=1, b=0x25 -> shift amount 5, result 0x20.
- Backpressure: hold i_ready=0 for 3 cycles after an ADD -> o_result is stable and o_ready=0. Then raise i_ready with i_valid=1 and an OR op -> both pop and accept occur on the same edge, and the OR result appears the next cycle.
- Flush: assert i_flush during an SLL of 20 when rem=10 -> o_valid never rises and o_ready=1 the next cycle. Repeat with i_rst_n pulsed low mid-SHIFT -> all outputs return to 0 asynchronously.
- Illegal: i_ALUControl=4'b1100 -> o_illegal 1, o_result 0, o_zero 1, latency 1. A following legal ADD clears o_illegal.
